// File: rtl/lut_pkg.sv
// Shared definitions for the programmable LUT bank: config states,
// table-width helper and the power-up truth table (minterms 0,2,4,6,7).
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    localparam logic [7:0] DEFAULT_TT = 8'hD5;

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial table loader: collects TT_W bits MSB first into a shadow word,
// then strobes commit for one cycle so the top can swap the table in.
// Ports: clock, reset (async, active high); cfg_start/cfg_ch/cfg_valid/
// cfg_bit/cfg_abort in; cfg_busy/cfg_done/cfg_err status out;
// commit, commit_ch, shadow towards the table store.
module lut_cfg_loader #(
    parameter int N_IN = 3,
    parameter int N_CH = 2,
    parameter int CW   = 1,
    parameter logic [(2**N_IN)-1:0] DEFAULT_TT = 8'hD5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic [CW-1:0]          cfg_ch,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    input  logic                   cfg_abort,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   commit,
    output logic [CW-1:0]          commit_ch,
    output logic [(2**N_IN)-1:0]   shadow
);
    import lut_pkg::*;

    localparam int TT_W = tt_width(N_IN);
    localparam logic [N_IN-1:0] LAST = N_IN'(TT_W - 1);
    localparam logic [CW:0] N_CH_W = (CW + 1)'(N_CH);

    cfg_state_t        state, state_nx;
    logic [N_IN-1:0]   cnt, cnt_nx;
    logic [TT_W-1:0]   shadow_nx;
    logic [CW-1:0]     ch_nx;
    logic              err_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= DEFAULT_TT;
            commit_ch <= '0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shadow    <= shadow_nx;
            commit_ch <= ch_nx;
            cfg_err   <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        ch_nx     = commit_ch;
        err_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    if ({1'b0, cfg_ch} < N_CH_W) begin
                        ch_nx    = cfg_ch;
                        cnt_nx   = '0;
                        state_nx = LOAD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    state_nx = IDLE;
                end else if (cfg_valid) begin
                    shadow_nx = {shadow[TT_W-2:0], cfg_bit};
                    cnt_nx    = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nx = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign cfg_busy = (state != IDLE);
    assign commit   = (state == COMMIT);
    assign cfg_done = commit;

endmodule

// File: rtl/prog_lut_bank.sv
// Bank of N_CH reloadable truth tables over N_IN shared inputs, each
// output ANDed with its gate bit; results are registered (1-cycle latency).
// Ports: clock, reset (async, active high); cfg_* serial config port;
// in_valid/in_vec/gate in; out_valid/out_raw/out_gated registered out.
module prog_lut_bank #(
    parameter int N_IN = 3,
    parameter int N_CH = 2,
    parameter logic [(2**N_IN)-1:0] DEFAULT_TT = lut_pkg::DEFAULT_TT,
    parameter int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [CW-1:0]     cfg_ch,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    input  logic              cfg_abort,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              in_valid,
    input  logic [N_IN-1:0]   in_vec,
    input  logic [N_CH-1:0]   gate,
    output logic              out_valid,
    output logic [N_CH-1:0]   out_raw,
    output logic [N_CH-1:0]   out_gated
);
    import lut_pkg::*;

    localparam int TT_W = tt_width(N_IN);

    logic              commit;
    logic [CW-1:0]     commit_ch;
    logic [TT_W-1:0]   shadow;
    logic [TT_W-1:0]   active [N_CH];
    logic [N_CH-1:0]   lut_bit;

    lut_cfg_loader #(
        .N_IN       (N_IN),
        .N_CH       (N_CH),
        .CW         (CW),
        .DEFAULT_TT (DEFAULT_TT)
    ) u_loader (
        .clock     (clock),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_ch    (cfg_ch),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_abort (cfg_abort),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .commit    (commit),
        .commit_ch (commit_ch),
        .shadow    (shadow)
    );

    // Swap happens on the COMMIT edge, so a sample taken in that
    // same cycle still reads the old table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                active[c] <= DEFAULT_TT;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (commit && commit_ch == CW'(c)) begin
                    active[c] <= shadow;
                end
            end
        end
    end

    always_comb begin
        lut_bit = '0;
        for (int c = 0; c < N_CH; c++) begin
            lut_bit[c] = active[c][in_vec];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_raw   <= '0;
            out_gated <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_raw   <= lut_bit;
                out_gated <= lut_bit & gate;
            end
        end
    end

endmodule

// File: tb/tb_prog_lut_bank.sv
// Self-checking bench for prog_lut_bank: per-cycle model comparison
// plus directed literal checks; a second 1-channel instance covers cfg_err.
module tb_prog_lut_bank;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       cfg_start, cfg_valid, cfg_bit, cfg_abort;
    logic [0:0] cfg_ch;
    logic       cfg_busy, cfg_done, cfg_err;
    logic       in_valid;
    logic [2:0] in_vec;
    logic [1:0] gate;
    logic       out_valid;
    logic [1:0] out_raw, out_gated;

    logic       c1_start, c1_valid, c1_bit, c1_abort;
    logic [0:0] c1_ch;
    logic       c1_busy, c1_done, c1_err;
    logic       c1_in_valid;
    logic [2:0] c1_in_vec;
    logic [0:0] c1_gate;
    logic       c1_out_valid;
    logic [0:0] c1_out_raw, c1_out_gated;

    prog_lut_bank #(.N_IN(3), .N_CH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_ch    (cfg_ch),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_abort (cfg_abort),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .gate      (gate),
        .out_valid (out_valid),
        .out_raw   (out_raw),
        .out_gated (out_gated)
    );

    prog_lut_bank #(.N_IN(3), .N_CH(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .cfg_start (c1_start),
        .cfg_ch    (c1_ch),
        .cfg_valid (c1_valid),
        .cfg_bit   (c1_bit),
        .cfg_abort (c1_abort),
        .cfg_busy  (c1_busy),
        .cfg_done  (c1_done),
        .cfg_err   (c1_err),
        .in_valid  (c1_in_valid),
        .in_vec    (c1_in_vec),
        .gate      (c1_gate),
        .out_valid (c1_out_valid),
        .out_raw   (c1_out_raw),
        .out_gated (c1_out_gated)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Model: tables as plain bytes, a load as "collect 8 bits by index",
    // then one cycle of pending commit before the table changes.
    logic [7:0] m_tt [2];
    logic       m_load, m_pend, m_err, m_valid;
    logic [1:0] m_raw, m_gated;
    logic [7:0] m_word;
    int         m_cnt;
    logic       m_ch;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_tt[0] <= 8'hD5;
            m_tt[1] <= 8'hD5;
            m_load  <= 1'b0;
            m_pend  <= 1'b0;
            m_err   <= 1'b0;
            m_valid <= 1'b0;
            m_raw   <= 2'b00;
            m_gated <= 2'b00;
            m_word  <= 8'h00;
            m_cnt   <= 0;
            m_ch    <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                m_raw   <= {m_tt[1][in_vec], m_tt[0][in_vec]};
                m_gated <= {m_tt[1][in_vec], m_tt[0][in_vec]} & gate;
            end
            m_err <= 1'b0;
            if (m_pend) begin
                m_tt[m_ch] <= m_word;
                m_pend     <= 1'b0;
            end else if (m_load) begin
                if (cfg_abort) begin
                    m_load <= 1'b0;
                end else if (cfg_valid) begin
                    m_word[7-m_cnt] <= cfg_bit;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 7) begin
                        m_load <= 1'b0;
                        m_pend <= 1'b1;
                    end
                end
            end else if (cfg_start) begin
                if (int'(cfg_ch) < 2) begin
                    m_load <= 1'b1;
                    m_ch   <= cfg_ch;
                    m_cnt  <= 0;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            check("cmp_out_raw", 32'(out_raw), 32'(m_raw));
            check("cmp_out_gated", 32'(out_gated), 32'(m_gated));
            check("cmp_cfg_busy", 32'(cfg_busy), 32'(m_load | m_pend));
            check("cmp_cfg_done", 32'(cfg_done), 32'(m_pend));
            check("cmp_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic eval(input logic [2:0] v, input logic [1:0] g);
        in_valid = 1'b1;
        in_vec   = v;
        gate     = g;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start(input logic ch);
        cfg_start = 1'b1;
        cfg_ch    = ch;
        tick();
        cfg_start = 1'b0;
    endtask

    // Sends n bits MSB first; with gaps, an idle cycle precedes each bit.
    // Returns right after the edge that accepted the last bit.
    task automatic send_bits(input logic [7:0] w, input int n,
                             input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_bit   = w[7-i];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_ch    = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        cfg_abort = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 3'b000;
        gate      = 2'b11;
        c1_start  = 1'b0;
        c1_ch     = 1'b0;
        c1_valid  = 1'b0;
        c1_bit    = 1'b0;
        c1_abort  = 1'b0;
        c1_in_valid = 1'b0;
        c1_in_vec   = 3'b000;
        c1_gate     = 1'b1;
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_raw", 32'(out_raw), 32'd0);
        check("rst_out_gated", 32'(out_gated), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);

        eval(3'b001, 2'b11);
        check("dflt_001_raw", 32'(out_raw), 32'd0);
        check("dflt_001_valid", 32'(out_valid), 32'd1);
        eval(3'b111, 2'b11);
        check("dflt_111_raw", 32'(out_raw), 32'h3);
        check("dflt_111_gated", 32'(out_gated), 32'h3);
        eval(3'b111, 2'b01);
        check("gate01_gated", 32'(out_gated), 32'h1);
        check("gate01_raw", 32'(out_raw), 32'h3);
        tick();
        check("hold_raw", 32'(out_raw), 32'h3);
        check("hold_valid", 32'(out_valid), 32'd0);

        // Load ch1 = 0x96 with gaps; a bit alongside cfg_start is dropped.
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        start(1'b1);
        cfg_valid = 1'b0;
        check("ld_busy_after_start", 32'(cfg_busy), 32'd1);
        send_bits(8'h96, 8, 1'b1);
        check("ld_done_commit", 32'(cfg_done), 32'd1);
        check("ld_busy_commit", 32'(cfg_busy), 32'd1);
        tick();
        check("ld_done_after", 32'(cfg_done), 32'd0);
        check("ld_busy_after", 32'(cfg_busy), 32'd0);
        eval(3'b011, 2'b11);
        check("ld_011_raw", 32'(out_raw), 32'h0);
        eval(3'b111, 2'b11);
        check("ld_111_raw", 32'(out_raw), 32'h3);
        eval(3'b100, 2'b11);
        check("ld_100_raw", 32'(out_raw), 32'h3);

        // Abort after 4 bits, with cfg_valid in the same cycle.
        start(1'b0);
        send_bits(8'h0F, 4, 1'b0);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check("abort_busy", 32'(cfg_busy), 32'd0);
        check("abort_done", 32'(cfg_done), 32'd0);
        tick();
        check("abort_done2", 32'(cfg_done), 32'd0);
        eval(3'b101, 2'b11);
        check("abort_101_ch0", 32'(out_raw[0]), 32'd0);
        eval(3'b110, 2'b11);
        check("abort_110_ch0", 32'(out_raw[0]), 32'd1);

        // Commit boundary with continuous evaluation of 3'b001.
        in_valid = 1'b1;
        in_vec   = 3'b001;
        gate     = 2'b11;
        start(1'b0);
        send_bits(8'hFF, 8, 1'b0);
        check("cb_last_bit_ch0", 32'(out_raw[0]), 32'd0);
        tick();
        check("cb_commit_ch0", 32'(out_raw[0]), 32'd0);
        check("cb_commit_ch1", 32'(out_raw[1]), 32'd1);
        tick();
        check("cb_next_ch0", 32'(out_raw[0]), 32'd1);
        in_valid = 1'b0;
        tick();

        // Reset while loading ch1 with 5 bits of a new table.
        in_valid = 1'b1;
        in_vec   = 3'b111;
        start(1'b1);
        send_bits(8'h3C, 5, 1'b0);
        check("rml_raw_before", 32'(out_raw), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        check("rml_valid_async", 32'(out_valid), 32'd0);
        check("rml_raw_async", 32'(out_raw), 32'd0);
        check("rml_gated_async", 32'(out_gated), 32'd0);
        check("rml_busy_async", 32'(cfg_busy), 32'd0);
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        eval(3'b011, 2'b11);
        check("rml_011_raw", 32'(out_raw), 32'h0);
        eval(3'b000, 2'b11);
        check("rml_000_raw", 32'(out_raw), 32'h3);

        // Out-of-range channel on the 1-channel instance.
        c1_start = 1'b1;
        c1_ch    = 1'b1;
        tick();
        c1_start = 1'b0;
        check("err_pulse", 32'(c1_err), 32'd1);
        check("err_busy", 32'(c1_busy), 32'd0);
        tick();
        check("err_clear", 32'(c1_err), 32'd0);
        check("err_busy2", 32'(c1_busy), 32'd0);
        c1_in_valid = 1'b1;
        c1_in_vec   = 3'b111;
        tick();
        check("err_tt_111", 32'(c1_out_raw), 32'd1);
        c1_in_vec = 3'b001;
        tick();
        check("err_tt_001", 32'(c1_out_raw), 32'd0);
        c1_in_valid = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
